// File: rtl/aes_pkg.sv
// Shared AES types and GF(2^8) helpers for the encrypt and decrypt datapaths.
package aes_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [127:0] state_t;

    localparam logic [7:0] AES_POLY = 8'h1b;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? AES_POLY : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] x);
        return xtime(x);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] x);
        return xtime(x) ^ x;
    endfunction

endpackage

// File: rtl/mix_column_word.sv
// Combinational forward MixColumns on one 32-bit column (byte 0 in the top byte).
module mix_column_word
    import aes_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;

    assign {a0, a1, a2, a3} = col_in;

    assign b0 = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
    assign b1 = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
    assign b2 = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
    assign b3 = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);

    assign col_out = {b0, b1, b2, b3};

endmodule

// File: rtl/mix_columns_seq.sv
// Sequential AES MixColumns: accepts a state, mixes COLS_PER_CYCLE columns per clock
// in place, then holds the result until the downstream handshake completes.
module mix_columns_seq
    import aes_pkg::*;
#(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam int unsigned NCYC     = 4 / COLS_PER_CYCLE;
    localparam logic [1:0]  STEP     = 2'(COLS_PER_CYCLE);
    localparam logic [1:0]  LAST_COL = 2'((NCYC - 1) * COLS_PER_CYCLE);

    generate
        if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
            $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, COMPUTE, DONE} fsm_t;

    fsm_t         fsm;
    word_t  [3:0] work;  // column c lives in work[3-c]
    logic   [1:0] col;

    word_t        mixed [COLS_PER_CYCLE];
    logic   [1:0] slot  [COLS_PER_CYCLE];

    for (genvar k = 0; k < COLS_PER_CYCLE; k++) begin : g_col
        assign slot[k] = 2'd3 - (col + 2'(k));
        mix_column_word u_mix (
            .col_in  (work[slot[k]]),
            .col_out (mixed[k])
        );
    end

    assign out_state = work;
    assign in_ready  = (fsm == IDLE) || ((fsm == DONE) && out_ready);

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm       <= IDLE;
            work      <= '0;
            col       <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    if (in_valid) begin
                        work <= in_state;
                        col  <= '0;
                        busy <= 1'b1;
                        fsm  <= COMPUTE;
                    end
                end
                COMPUTE: begin
                    for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                        work[slot[k]] <= mixed[k];
                    end
                    col <= col + STEP;
                    if (col == LAST_COL) begin
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                        fsm       <= DONE;
                    end
                end
                DONE: begin
                    // A transfer and a new accept may share the same edge.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            work <= in_state;
                            col  <= '0;
                            busy <= 1'b1;
                            fsm  <= COMPUTE;
                        end else begin
                            fsm <= IDLE;
                        end
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// Directed and streaming checks of mix_columns_seq for COLS_PER_CYCLE = 1, 2, 4.
module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         reset;
    logic         iv   [3];
    logic         ir   [3];
    logic [127:0] ist  [3];
    logic         ov   [3];
    logic         ordy [3];
    logic [127:0] ost  [3];
    logic         bz   [3];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]), .in_state(ist[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(ost[0]), .busy(bz[0]));
    mix_columns_seq #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]), .in_state(ist[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(ost[1]), .busy(bz[1]));
    mix_columns_seq #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]), .in_state(ist[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_state(ost[2]), .busy(bz[2]));

    // Shift-and-add GF(2^8) multiply, independent of the xtime formulation.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s);
        logic [127:0] r;
        logic [7:0] a [4];
        for (int c = 0; c < 4; c++) begin
            for (int j = 0; j < 4; j++) a[j] = s[127 - 32*c - 8*j -: 8];
            r[127 - 32*c -: 8] = gf_mul(a[0], 8'd2) ^ gf_mul(a[1], 8'd3) ^ a[2] ^ a[3];
            r[119 - 32*c -: 8] = a[0] ^ gf_mul(a[1], 8'd2) ^ gf_mul(a[2], 8'd3) ^ a[3];
            r[111 - 32*c -: 8] = a[0] ^ a[1] ^ gf_mul(a[2], 8'd2) ^ gf_mul(a[3], 8'd3);
            r[103 - 32*c -: 8] = gf_mul(a[0], 8'd3) ^ a[1] ^ a[2] ^ gf_mul(a[3], 8'd2);
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Accept one state on DUT d, wait for the result, check latency and value, then drain.
    task automatic run_one(input int d, input logic [127:0] st, input logic [127:0] exp,
                           input int lat_req, input string name);
        int lat;
        chk({name, " in_ready idle"}, 128'(ir[d]), 128'd1);
        iv[d] = 1'b1; ist[d] = st; ordy[d] = 1'b0;
        @(negedge clk);
        iv[d] = 1'b0; ist[d] = ~st;
        chk({name, " busy"}, 128'(bz[d]), 128'd1);
        chk({name, " in_ready busy"}, 128'(ir[d]), 128'd0);
        lat = 0;
        while (!ov[d] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk({name, " latency"}, 128'(lat), 128'(lat_req));
        chk({name, " out_state"}, ost[d], exp);
        chk({name, " busy done"}, 128'(bz[d]), 128'd0);
        ordy[d] = 1'b1;
        @(negedge clk);
        ordy[d] = 1'b0;
        chk({name, " out_valid drop"}, 128'(ov[d]), 128'd0);
    endtask

    typedef struct {
        logic [127:0] in;
        logic [127:0] exp;
        string        name;
    } vec_t;

    vec_t vecs [3];
    logic [127:0] a_st, b_st, held;
    logic [127:0] sb [$];
    int lat, sent, rcv, cyc;
    logic acc, xfer;

    initial begin
        vecs[0] = '{128'hdb135345_db135345_db135345_db135345,
                    128'h8e4da1bc_8e4da1bc_8e4da1bc_8e4da1bc, "colvec1"};
        vecs[1] = '{128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5,
                    128'h046681e5_e0cb199a_48f8d37a_2806264c, "fips"};
        vecs[2] = '{128'h01010101_c6c6c6c6_d4d4d4d5_2d26314c,
                    128'h01010101_c6c6c6c6_d5d5d7d6_4d7ebdf8, "ident"};

        for (int d = 0; d < 3; d++) begin
            iv[d] = 1'b0; ist[d] = '0; ordy[d] = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset out_valid d%0d", d), 128'(ov[d]), 128'd0);
            chk($sformatf("reset busy d%0d", d), 128'(bz[d]), 128'd0);
            chk($sformatf("reset in_ready d%0d", d), 128'(ir[d]), 128'd1);
            chk($sformatf("reset out_state d%0d", d), ost[d], 128'd0);
        end

        for (int d = 0; d < 3; d++) begin
            for (int v = 0; v < 3; v++) begin
                run_one(d, vecs[v].in, vecs[v].exp, 4 >> d,
                        $sformatf("%s d%0d", vecs[v].name, d));
            end
        end

        // Backpressure with ignored in_valid pulses, then same-edge transfer and accept.
        a_st = 128'h00112233_44556677_8899aabb_ccddeeff;
        b_st = 128'hf0e1d2c3_b4a59687_78695a4b_3c2d1e0f;
        iv[0] = 1'b1; ist[0] = a_st;
        @(negedge clk);
        iv[0] = 1'b0;
        lat = 0;
        while (!ov[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp first latency", 128'(lat), 128'd4);
        held = mix_ref(a_st);
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp hold state %0d", i), ost[0], held);
            chk($sformatf("bp in_ready %0d", i), 128'(ir[0]), 128'd0);
            chk($sformatf("bp out_valid %0d", i), 128'(ov[0]), 128'd1);
            iv[0] = i[0];
            ist[0] = rnd128();
            @(negedge clk);
        end
        iv[0] = 1'b1; ist[0] = b_st; ordy[0] = 1'b1;
        #1;
        chk("bp in_ready follows out_ready", 128'(ir[0]), 128'd1);
        @(negedge clk);
        iv[0] = 1'b0; ordy[0] = 1'b0; ist[0] = '0;
        chk("b2b out_valid drop", 128'(ov[0]), 128'd0);
        chk("b2b busy", 128'(bz[0]), 128'd1);
        lat = 0;
        while (!ov[0] && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("b2b latency", 128'(lat), 128'd4);
        chk("b2b out_state", ost[0], mix_ref(b_st));
        ordy[0] = 1'b1;
        @(negedge clk);
        ordy[0] = 1'b0;

        // Reset in the second compute cycle.
        iv[0] = 1'b1; ist[0] = vecs[1].in;
        @(negedge clk);
        iv[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst out_valid", 128'(ov[0]), 128'd0);
        chk("midrst busy", 128'(bz[0]), 128'd0);
        chk("midrst in_ready", 128'(ir[0]), 128'd1);
        chk("midrst out_state", ost[0], 128'd0);
        a_st = 128'h3243f6a8_885a308d_313198a2_e0370734;
        run_one(0, a_st, mix_ref(a_st), 4, "after reset");

        // Randomized streaming with scoreboard.
        sent = 0; rcv = 0; cyc = 0;
        while (rcv < 1000 && cyc < 40000) begin
            iv[0] = (sent < 1000) && ($urandom_range(0, 3) != 0);
            ist[0] = rnd128();
            ordy[0] = ($urandom_range(0, 2) != 0);
            #1;
            acc = iv[0] && ir[0];
            xfer = ov[0] && ordy[0];
            if (xfer) begin
                if (sb.size() == 0) chk("stream unexpected output", 128'd1, 128'd0);
                else chk($sformatf("stream item %0d", rcv), ost[0], sb.pop_front());
                rcv++;
            end
            if (acc) begin
                sb.push_back(mix_ref(ist[0]));
                sent++;
            end
            @(negedge clk);
            cyc++;
        end
        iv[0] = 1'b0; ordy[0] = 1'b0;
        chk("stream received count", 128'(rcv), 128'd1000);
        chk("stream scoreboard empty", 128'(sb.size()), 128'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
